// File: rtl/cmd_parser_pkg.sv
// cmd_parser_pkg
// Shared definitions for the UART command parser: FSM state encoding,
// command opcodes, response frame markers, NAK reason codes and the
// maximum payload length. Small helpers map an opcode to its required
// payload length.
package cmd_parser_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH       = 3'd0,
        ST_WAIT_SYNC   = 3'd1,
        ST_GET_CMD     = 3'd2,
        ST_GET_LEN     = 3'd3,
        ST_GET_PAYLOAD = 3'd4,
        ST_GET_CHK     = 3'd5,
        ST_EXECUTE     = 3'd6,
        ST_RESPOND     = 3'd7
    } parser_state_t;

    localparam logic [7:0] OP_PING = 8'h00;
    localparam logic [7:0] OP_WAVE = 8'h01;
    localparam logic [7:0] OP_FREQ = 8'h02;
    localparam logic [7:0] OP_AMPL = 8'h03;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam logic [7:0] NAK_CHECKSUM = 8'h01;
    localparam logic [7:0] NAK_LENGTH   = 8'h02;
    localparam logic [7:0] NAK_OPCODE   = 8'h03;
    localparam logic [7:0] NAK_TIMEOUT  = 8'h04;

    localparam logic [7:0] MAX_LEN = 8'd8;

    function automatic logic op_known(input logic [7:0] op);
        return (op <= OP_AMPL);
    endfunction

    // Required payload length per opcode; only meaningful for known opcodes.
    function automatic logic [7:0] op_len(input logic [7:0] op);
        case (op)
            OP_PING: return 8'd0;
            OP_WAVE: return 8'd1;
            OP_FREQ: return 8'd4;
            OP_AMPL: return 8'd2;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/cmd_resp_tx.sv
// cmd_resp_tx
// Drives the UART TX side for one two-byte response frame.
// On start it loads the response vector, sets tx_size to 2 and releases
// tx_reset. It then waits for tx_done to be seen low and afterwards high,
// puts the UART TX back into reset and pulses resp_done for one cycle.
// The loaded response stays on tx_bytevect until the next start or reset.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 one-cycle request to send {resp_b1, resp_b0}
//   resp_b0, resp_b1      first / second response byte
//   tx_done               UART TX complete flag
//   tx_bytevect, tx_size  response vector and length to the UART
//   tx_reset              UART TX reset (high = idle, low = transmit)
//   resp_done             one-cycle pulse when the handshake completes
module cmd_resp_tx
    import cmd_parser_pkg::*;
#(
    parameter int TX_PACKET_SIZE = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [7:0]                    resp_b0,
    input  logic [7:0]                    resp_b1,
    input  logic                          tx_done,
    output logic [8*TX_PACKET_SIZE-1:0]   tx_bytevect,
    output logic [15:0]                   tx_size,
    output logic                          tx_reset,
    output logic                          resp_done
);

    logic busy;
    logic seen_low;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_bytevect <= '0;
            tx_size     <= 16'd0;
            tx_reset    <= 1'b1;
            resp_done   <= 1'b0;
            busy        <= 1'b0;
            seen_low    <= 1'b0;
        end else begin
            resp_done <= 1'b0;
            if (start) begin
                tx_bytevect       <= '0;
                tx_bytevect[7:0]  <= resp_b0;
                tx_bytevect[15:8] <= resp_b1;
                tx_size           <= 16'd2;
                tx_reset          <= 1'b0;
                busy              <= 1'b1;
                seen_low          <= 1'b0;
            end else if (busy) begin
                // A stale high tx_done from the previous frame must not end
                // this one, so a low phase has to be observed first.
                if (!tx_done) begin
                    seen_low <= 1'b1;
                end else if (seen_low) begin
                    tx_reset  <= 1'b1;
                    busy      <= 1'b0;
                    resp_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Frames and decodes host commands from the UART RX byte vector, updates
// the waveform / frequency / amplitude registers and returns an ACK or
// NAK frame through cmd_resp_tx. Frame: SYNC CMD LEN payload[LEN] [CHK].
//
// Build option: CMD_PARSER_CHECKSUM_EN - when defined, every frame ends in
// a CHK byte (XOR of CMD, LEN and payload) which is verified; otherwise
// frames carry no CHK byte.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   rx_bytevect, rx_size_ready   UART RX bytes and valid byte count
//   rx_buffer_full               UART RX full flag
//   rx_reset                     UART RX buffer clear (active high)
//   tx_bytevect, tx_size         response frame to the UART TX
//   tx_reset, tx_done            UART TX start/idle control and completion
//   wave_sel, freq_word,
//   amplitude                    configuration registers
//   cfg_update                   one-cycle pulse on any register write
//
// state          | meaning
// ---------------+---------------------------------------------------
// ST_FLUSH       | rx_reset 1 cycle, then 2 quiet cycles, rd_ind = 0
// ST_WAIT_SYNC   | discard bytes until SYNC; flush on overflow/full
// ST_GET_CMD     | fetch command byte
// ST_GET_LEN     | fetch length, reject LEN > 8
// ST_GET_PAYLOAD | collect LEN payload bytes
// ST_GET_CHK     | fetch checksum byte (checksum builds only)
// ST_EXECUTE     | validate, write register, choose ACK/NAK
// ST_RESPOND     | response handshake in progress
module uart_cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int         RX_PACKET_SIZE = 64,
    parameter int         TX_PACKET_SIZE = 64,
    parameter int         TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [8*RX_PACKET_SIZE-1:0]   rx_bytevect,
    input  logic [15:0]                   rx_size_ready,
    input  logic                          rx_buffer_full,
    output logic                          rx_reset,
    output logic [8*TX_PACKET_SIZE-1:0]   tx_bytevect,
    output logic [15:0]                   tx_size,
    output logic                          tx_reset,
    input  logic                          tx_done,
    output logic [1:0]                    wave_sel,
    output logic [31:0]                   freq_word,
    output logic [15:0]                   amplitude,
    output logic                          cfg_update
);

    localparam int          RX_IW    = $clog2(RX_PACKET_SIZE);
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);
`ifdef CMD_PARSER_CHECKSUM_EN
    localparam parser_state_t ST_AFTER_DATA = ST_GET_CHK;
`else
    localparam parser_state_t ST_AFTER_DATA = ST_EXECUTE;
`endif

    parser_state_t state, state_nx;

    logic [1:0]  flush_cnt;
    logic [15:0] rd_ind;
    logic [7:0]  cmd_q;
    logic [7:0]  len_q;
    logic [3:0]  pay_cnt;
    logic [63:0] pay_buf;
    logic [31:0] tmo_cnt;
    logic [7:0]  resp_b0, resp_b1;
    logic        resp_start;
    logic        resp_done;
`ifdef CMD_PARSER_CHECKSUM_EN
    logic [7:0]  chk_acc;
    logic [7:0]  chk_rx;
`endif

    logic        rx_avail;
    logic [7:0]  rx_byte;
    logic        tmo_hit;
    logic        fetch;
    logic        resp_load;
    logic [7:0]  resp_b0_nx, resp_b1_nx;
    logic        wr_wave, wr_freq, wr_amp;

    // Upper payload bytes are collected but no command uses them.
    logic        pay_unused;
    assign pay_unused = ^pay_buf[63:32];

    assign rx_avail = (rd_ind < 16'(RX_PACKET_SIZE)) && (rx_size_ready > rd_ind);
    assign rx_byte  = rx_bytevect[{rd_ind[RX_IW-1:0], 3'b000} +: 8];
    assign tmo_hit  = (tmo_cnt == 32'd0) && !rx_avail;
    assign rx_reset = (state == ST_FLUSH) && (flush_cnt == 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_FLUSH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        fetch      = 1'b0;
        resp_load  = 1'b0;
        resp_b0_nx = RSP_NAK;
        resp_b1_nx = NAK_TIMEOUT;
        wr_wave    = 1'b0;
        wr_freq    = 1'b0;
        wr_amp     = 1'b0;
        case (state)
            ST_FLUSH: begin
                if (flush_cnt == 2'd2) state_nx = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                if ((rd_ind >= 16'(RX_PACKET_SIZE)) || rx_buffer_full) begin
                    state_nx = ST_FLUSH;
                end else if (rx_avail) begin
                    fetch = 1'b1;
                    if (rx_byte == SYNC_BYTE) state_nx = ST_GET_CMD;
                end
            end
            ST_GET_CMD: begin
                if (rx_avail) begin
                    fetch    = 1'b1;
                    state_nx = ST_GET_LEN;
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    state_nx  = ST_RESPOND;
                end
            end
            ST_GET_LEN: begin
                if (rx_avail) begin
                    fetch = 1'b1;
                    if (rx_byte > MAX_LEN) begin
                        resp_load  = 1'b1;
                        resp_b1_nx = NAK_LENGTH;
                        state_nx   = ST_RESPOND;
                    end else if (rx_byte == 8'd0) begin
                        state_nx = ST_AFTER_DATA;
                    end else begin
                        state_nx = ST_GET_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    state_nx  = ST_RESPOND;
                end
            end
            ST_GET_PAYLOAD: begin
                if (rx_avail) begin
                    fetch = 1'b1;
                    if ({4'd0, pay_cnt} == len_q - 8'd1) state_nx = ST_AFTER_DATA;
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    state_nx  = ST_RESPOND;
                end
            end
            ST_GET_CHK: begin
                if (rx_avail) begin
                    fetch    = 1'b1;
                    state_nx = ST_EXECUTE;
                end else if (tmo_hit) begin
                    resp_load = 1'b1;
                    state_nx  = ST_RESPOND;
                end
            end
            ST_EXECUTE: begin
                resp_load = 1'b1;
                state_nx  = ST_RESPOND;
`ifdef CMD_PARSER_CHECKSUM_EN
                if (chk_rx != chk_acc) begin
                    resp_b1_nx = NAK_CHECKSUM;
                end else
`endif
                if (!op_known(cmd_q)) begin
                    resp_b1_nx = NAK_OPCODE;
                end else if (len_q != op_len(cmd_q)) begin
                    resp_b1_nx = NAK_LENGTH;
                end else begin
                    resp_b0_nx = RSP_ACK;
                    resp_b1_nx = cmd_q;
                    wr_wave    = (cmd_q == OP_WAVE);
                    wr_freq    = (cmd_q == OP_FREQ);
                    wr_amp     = (cmd_q == OP_AMPL);
                end
            end
            ST_RESPOND: begin
                if (resp_done) state_nx = ST_FLUSH;
            end
            default: state_nx = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt  <= 2'd0;
            rd_ind     <= 16'd0;
            cmd_q      <= 8'd0;
            len_q      <= 8'd0;
            pay_cnt    <= 4'd0;
            pay_buf    <= 64'd0;
            tmo_cnt    <= TMO_LOAD;
            resp_b0    <= 8'd0;
            resp_b1    <= 8'd0;
            resp_start <= 1'b0;
            wave_sel   <= 2'd0;
            freq_word  <= 32'd0;
            amplitude  <= 16'd0;
            cfg_update <= 1'b0;
`ifdef CMD_PARSER_CHECKSUM_EN
            chk_acc    <= 8'd0;
            chk_rx     <= 8'd0;
`endif
        end else begin
            resp_start <= resp_load;
            cfg_update <= wr_wave | wr_freq | wr_amp;
            flush_cnt  <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : 2'd0;

            if (state == ST_FLUSH)  rd_ind <= 16'd0;
            else if (fetch)         rd_ind <= rd_ind + 16'd1;

            // Idle-timeout down-counter, restarted by any byte or state change.
            if (fetch || (state_nx != state)) tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != 32'd0)        tmo_cnt <= tmo_cnt - 32'd1;

            if (fetch) begin
                case (state)
                    ST_GET_CMD: begin
                        cmd_q   <= rx_byte;
`ifdef CMD_PARSER_CHECKSUM_EN
                        chk_acc <= rx_byte;
`endif
                    end
                    ST_GET_LEN: begin
                        len_q   <= rx_byte;
                        pay_cnt <= 4'd0;
`ifdef CMD_PARSER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_byte;
`endif
                    end
                    ST_GET_PAYLOAD: begin
                        pay_buf[{pay_cnt[2:0], 3'b000} +: 8] <= rx_byte;
                        pay_cnt <= pay_cnt + 4'd1;
`ifdef CMD_PARSER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_byte;
`endif
                    end
`ifdef CMD_PARSER_CHECKSUM_EN
                    ST_GET_CHK: chk_rx <= rx_byte;
`endif
                    default: ;
                endcase
            end

            if (resp_load) begin
                resp_b0 <= resp_b0_nx;
                resp_b1 <= resp_b1_nx;
            end

            if (wr_wave) wave_sel  <= pay_buf[1:0];
            if (wr_freq) freq_word <= pay_buf[31:0];
            if (wr_amp)  amplitude <= pay_buf[15:0];
        end
    end

    cmd_resp_tx #(
        .TX_PACKET_SIZE (TX_PACKET_SIZE)
    ) u_resp_tx (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (resp_start),
        .resp_b0     (resp_b0),
        .resp_b1     (resp_b1),
        .tx_done     (tx_done),
        .tx_bytevect (tx_bytevect),
        .tx_size     (tx_size),
        .tx_reset    (tx_reset),
        .resp_done   (resp_done)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

    localparam int RXN = 64;
    localparam int TXN = 64;
    localparam int TMO = 1000;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [8*RXN-1:0]   rx_bytevect;
    logic [15:0]        rx_size_ready;
    logic               rx_buffer_full;
    logic               rx_reset;
    logic [8*TXN-1:0]   tx_bytevect;
    logic [15:0]        tx_size;
    logic               tx_reset;
    logic               tx_done;
    logic [1:0]         wave_sel;
    logic [31:0]        freq_word;
    logic [15:0]        amplitude;
    logic               cfg_update;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .RX_PACKET_SIZE (RXN),
        .TX_PACKET_SIZE (TXN),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_bytevect    (rx_bytevect),
        .rx_size_ready  (rx_size_ready),
        .rx_buffer_full (rx_buffer_full),
        .rx_reset       (rx_reset),
        .tx_bytevect    (tx_bytevect),
        .tx_size        (tx_size),
        .tx_reset       (tx_reset),
        .tx_done        (tx_done),
        .wave_sel       (wave_sel),
        .freq_word      (freq_word),
        .amplitude      (amplitude),
        .cfg_update     (cfg_update)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cfg_pulses  = 0;
    int pulse_base  = 0;

    always @(posedge clk) if (cfg_update === 1'b1) cfg_pulses <= cfg_pulses + 1;

    typedef struct packed {
        logic [15:0] resp;
        logic [1:0]  wave;
        logic [31:0] freq;
        logic [15:0] amp;
        logic [7:0]  pulses;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  m_wave = 2'd0;
    logic [31:0] m_freq = 32'd0;
    logic [15:0] m_amp  = 16'd0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        repeat (2) @(negedge clk);
        rx_bytevect[rx_size_ready*8 +: 8] = b;
        rx_size_ready = rx_size_ready + 16'd1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [63:0] pl);
        logic [7:0] c;
        c = cmd ^ len;
        push_byte(8'hA5);
        push_byte(cmd);
        push_byte(len);
        for (int i = 0; i < int'(len) && i < 8; i++) begin
            c = c ^ pl[8*i +: 8];
            push_byte(pl[8*i +: 8]);
        end
`ifdef CMD_PARSER_CHECKSUM_EN
        push_byte(c);
`endif
    endtask

    task automatic expect_resp(input logic [7:0] b0, input logic [7:0] b1, input int pulses);
        exp_t e;
        e.resp   = {b1, b0};
        e.wave   = m_wave;
        e.freq   = m_freq;
        e.amp    = m_amp;
        e.pulses = 8'(pulses);
        sb.push_back(e);
        pulse_base = cfg_pulses;
    endtask

    task automatic wait_flush();
        int n;
        n = 0;
        while (rx_reset !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("flush_start", rx_reset, 1);
        rx_size_ready = 16'd0;
        rx_bytevect   = '0;
        n = 0;
        while (rx_reset !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("flush_end", rx_reset, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_response(output int waited);
        exp_t             e;
        logic [8*TXN-1:0] ev;
        int               n;
        n = 0;
        while (tx_reset !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        waited = n;
        chk("tx_start", tx_reset, 0);
        chk("sb_depth", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ev = '0;
            ev[15:0] = e.resp;
            chk("tx_bytes", tx_bytevect, ev);
            chk("tx_size", tx_size, 2);
            chk("wave_sel", wave_sel, e.wave);
            chk("freq_word", freq_word, e.freq);
            chk("amplitude", amplitude, e.amp);
            chk("cfg_pulses", 32'(cfg_pulses - pulse_base), 32'(e.pulses));
        end
        tx_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("tx_hold", tx_reset, 0);
        tx_done = 1'b1;
        n = 0;
        while (rx_reset !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("rx_reset_after_tx", rx_reset, 1);
        chk("tx_idle", tx_reset, 1);
        wait_flush();
    endtask

    task automatic check_reset_values();
        chk("rst_rx_reset", rx_reset, 1);
        chk("rst_tx_reset", tx_reset, 1);
        chk("rst_tx_bytes", tx_bytevect, 0);
        chk("rst_tx_size", tx_size, 0);
        chk("rst_wave", wave_sel, 0);
        chk("rst_freq", freq_word, 0);
        chk("rst_amp", amplitude, 0);
        chk("rst_cfg_update", cfg_update, 0);
    endtask

    initial begin
        int w;
        reset_n        = 1'b0;
        rx_bytevect    = '0;
        rx_size_ready  = 16'd0;
        rx_buffer_full = 1'b0;
        tx_done        = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        wait_flush();

        // frequency write
        m_freq = 32'h12345678;
        expect_resp(8'h06, 8'h02, 1);
        send_frame(8'h02, 8'h04, 64'h12345678);
        check_response(w);

        // leading garbage, wave write
        m_wave = 2'd2;
        expect_resp(8'h06, 8'h01, 1);
        push_byte(8'h33);
        send_frame(8'h01, 8'h01, 64'h02);
        check_response(w);

`ifdef CMD_PARSER_CHECKSUM_EN
        // corrupted checksum
        expect_resp(8'h15, 8'h01, 0);
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h01);
        push_byte(8'h02); push_byte(8'h03);
        check_response(w);
`endif

        // unknown opcode
        expect_resp(8'h15, 8'h03, 0);
        send_frame(8'h07, 8'h00, 64'h0);
        check_response(w);

        // wrong length for amplitude
        expect_resp(8'h15, 8'h02, 0);
        send_frame(8'h03, 8'h01, 64'h55);
        check_response(w);

        // amplitude write
        m_amp = 16'h1234;
        expect_resp(8'h06, 8'h03, 1);
        send_frame(8'h03, 8'h02, 64'h1234);
        check_response(w);

        // ping
        expect_resp(8'h06, 8'h00, 0);
        send_frame(8'h00, 8'h00, 64'h0);
        check_response(w);

        // LEN above maximum is rejected at the length byte
        expect_resp(8'h15, 8'h02, 0);
        push_byte(8'hA5); push_byte(8'h01); push_byte(8'h09);
        check_response(w);

        // mid-frame silence: NAK 04 one timeout after the last byte
        expect_resp(8'h15, 8'h04, 0);
        push_byte(8'hA5); push_byte(8'h02);
        check_response(w);
        chk("tmo_latency", (w >= 1000 && w <= 1004), 1);

        // reset during payload collection
        push_byte(8'hA5); push_byte(8'h02); push_byte(8'h04);
        push_byte(8'h78); push_byte(8'h56);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        m_wave = 2'd0; m_freq = 32'd0; m_amp = 16'd0;
        reset_n = 1'b1;
        wait_flush();
        m_wave = 2'd3;
        expect_resp(8'h06, 8'h01, 1);
        send_frame(8'h01, 8'h01, 64'h03);
        check_response(w);

        chk("sb_final", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Command framer and decoder that sits directly downstream of the `uart` block in the function-generator design. It consumes bytes as they accumulate in the UART RX byte vector and parses framed host commands. It updates the waveform, frequency and amplitude configuration registers, then drives the UART TX side to return an ACK/NAK frame. It owns both UART reset lines: it clears the RX buffer after every frame and starts each TX response.

## Interface
- `RX_PACKET_SIZE`, 64: byte capacity of the UART RX vector; must be ≥ 16.
- `TX_PACKET_SIZE`, 64: byte capacity of the UART TX vector; must be ≥ 2.
- `TIMEOUT_CYCLES`, 5000000: idle cycles allowed mid-frame (100 ms at 50 MHz).
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  50 MHz system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_bytevect`  in  8*RX_PACKET_SIZE  UART received bytes; byte k is at [8k+7:8k].
- `rx_size_ready`  in  16  count of bytes valid in `rx_bytevect`.
- `rx_buffer_full`  in  1  UART RX full flag.
- `rx_reset`  out  1  active-high UART RX reset.
- `tx_bytevect`  out  8*TX_PACKET_SIZE  response bytes; unused bytes are 0.
- `tx_size`  out  16  response length.
- `tx_reset`  out  1  UART TX reset; held high = idle, released = transmit.
- `tx_done`  in  1  UART TX complete flag.
- `wave_sel`  out  2  waveform select.
- `freq_word`  out  32  DDS tuning word.
- `amplitude`  out  16  amplitude scale.
- `cfg_update`  out  1  one-cycle pulse when any config register is written.

## Operation
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.
- Commands:
  - 0x00 ping: LEN 0.
  - 0x01 wave: LEN 1; `wave_sel` = payload[1:0].
  - 0x02 freq: LEN 4; `freq_word` is little-endian.
  - 0x03 amplitude: LEN 2; `amplitude` is little-endian.
- Internal read index `rd_ind` (16 bit). A byte is fetched when `rx_size_ready > rd_ind`, taking byte `rd_ind` and incrementing the index. At most one byte is fetched per cycle.
- States:
  - FLUSH: `rx_reset`=1 for 1 cycle, then 0 for 2 cycles; `rd_ind`=0; then → WAIT_SYNC.
  - WAIT_SYNC: discard non-SYNC bytes; SYNC → GET_CMD. If `rd_ind` reaches RX_PACKET_SIZE or `rx_buffer_full`=1 → FLUSH.
  - GET_CMD → GET_LEN.
  - GET_LEN: LEN > 8 → NAK 0x02; LEN 0 → GET_CHK; otherwise → GET_PAYLOAD.
  - GET_PAYLOAD: collect LEN bytes into an 8-byte buffer → GET_CHK.
  - GET_CHK → EXECUTE.
  - EXECUTE:
    - checksum mismatch → NAK 0x01;
    - unknown CMD → NAK 0x03;
    - LEN wrong for CMD → NAK 0x02;
    - otherwise write the target register, pulse `cfg_update` (not for ping), and send ACK.
  - RESPOND: load the response, release `tx_reset`, wait until `tx_done` is seen 0 and then 1, set `tx_reset`=1 → FLUSH.
- Response frames: ACK = [0x06, CMD]; NAK = [0x15, code]. `tx_size`=2.
- Timeout: in any state from GET_CMD through GET_CHK, if no byte arrives for TIMEOUT_CYCLES → NAK 0x04.
- Bytes received during RESPOND are discarded by the following FLUSH. The host waits for the response before sending the next frame.

## Timing
- Reset values:
  - `rx_reset`=1, `tx_reset`=1;
  - `tx_bytevect`=0, `tx_size`=0;
  - `wave_sel`=0, `freq_word`=0, `amplitude`=0, `cfg_update`=0.
- After `reset_n` deasserts, the block enters FLUSH.
- Byte fetch latency is 1 cycle after `rx_size_ready` exceeds `rd_ind`.
- Config registers and `cfg_update` change on the EXECUTE cycle, 1 cycle after CHK is fetched.
- `tx_reset` falls 1 cycle after EXECUTE.
- The timeout counter is 32 bit and is cleared on every fetched byte and on every state entry.
- `reset_n` low mid-frame or mid-response aborts at once. Config registers return to their reset values.

## Configuration
- `CMD_PARSER_CHECKSUM_EN` defined: the CHK byte is present in every frame and is verified.
- Not defined: frames carry no CHK byte. GET_PAYLOAD, or GET_LEN when LEN=0, goes directly to EXECUTE, and NAK 0x01 never occurs.

## Structure
- `cmd_parser_pkg` holds:
  - state encodings;
  - opcodes 0x00–0x03;
  - ACK 0x06 / NAK 0x15;
  - NAK codes 0x01–0x04;
  - max LEN 8.
- One sub-module, `cmd_resp_tx`, owns the RESPOND handshake. It loads the response vector, controls `tx_reset`, detects the `tx_done` low-then-high edge, and reports completion to the parser.

## Test plan
- A5 02 04 78 56 34 12 0E → `freq_word`=0x12345678, one `cfg_update` pulse, TX sends 06 02, then `rx_reset` pulses.
- 33 A5 01 01 02 02 → the leading 0x33 is discarded, `wave_sel`=2, ACK 06 01.
- A5 01 01 02 03 (checksum enabled) → `wave_sel` unchanged, no `cfg_update`, TX sends 15 01.
- A5 07 00 07 → NAK 15 03. A5 03 01 55 57 → NAK 15 02, `amplitude` unchanged.
- A5 02 then silence for TIMEOUT_CYCLES (bench sets it to 1000) → NAK 15 04 at cycle 1000 after the 02 byte, then FLUSH.
- `reset_n` pulsed low during GET_PAYLOAD → all outputs return to reset values, `rx_reset`=1, and the next full frame parses correctly.
